// File: rtl/fir_decim_if.sv
// FIFO-facing signal bundle for the decimating FIR: the input FIFO read side
// and the output FIFO write side. The master modport is the filter; the slave
// modport is the FIFO environment around it.
interface fir_decim_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] in_dout;
    logic                  in_empty;
    logic                  in_rd_en;
    logic [DATA_WIDTH-1:0] out_din;
    logic                  out_full;
    logic                  out_wr_en;

    modport master (
        input  in_dout,
        input  in_empty,
        input  out_full,
        output in_rd_en,
        output out_din,
        output out_wr_en
    );

    modport slave (
        output in_dout,
        output in_empty,
        output out_full,
        input  in_rd_en,
        input  out_din,
        input  out_wr_en
    );
endinterface

// File: rtl/fir_decim.sv
// Decimating real FIR: gathers DECIM new samples into the delay line, runs a
// serial one-tap-per-cycle MAC over all TAPS taps, then writes one result.
// Each product is scaled down by 2^BITS with truncation toward zero so the
// output is bit-exact with the C integer-division reference. BITS must be >= 1.
module fir_decim #(
    parameter int TAPS       = 32,
    parameter int DECIM      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = 10,
    parameter logic signed [DATA_WIDTH-1:0] COEFFS [TAPS] =
        '{0: DATA_WIDTH'(1 << BITS), default: '0}
) (
    input  logic        clk,
    input  logic        reset,
    fir_decim_if.master bus
);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int TAP_W  = $clog2(TAPS);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIM - 1);
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);

    typedef enum logic [1:0] {S_FILL, S_MAC, S_OUT} state_t;

    state_t                       state_q, state_d;
    logic signed [DATA_WIDTH-1:0] x_q [TAPS];
    logic signed [DATA_WIDTH-1:0] x_d [TAPS];
    logic [PH_W-1:0]              phase_q, phase_d;
    logic [TAP_W-1:0]             tap_q, tap_d;
    logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0] out_din_q, out_din_d;

    logic signed [PROD_W-1:0]     coef_ext, x_ext, prod, prod_adj, prod_shr;
    logic signed [DATA_WIDTH-1:0] deq;
    logic                         rd_en, wr_en;

    // Current tap product, scaled by 2^-BITS rounding toward zero
    always_comb begin
        coef_ext = PROD_W'(COEFFS[tap_q]);
        x_ext    = PROD_W'(x_q[tap_q]);
        prod     = coef_ext * x_ext;
        prod_adj = prod;
        if (prod[PROD_W-1]) begin
            // Negative products are biased so the arithmetic shift truncates toward zero
            prod_adj = prod + {{(PROD_W-BITS){1'b0}}, {BITS{1'b1}}};
        end
        prod_shr = prod_adj >>> BITS;
        deq      = prod_shr[DATA_WIDTH-1:0];
    end

    // Next-state, datapath updates and FIFO handshakes
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        phase_d   = phase_q;
        tap_d     = tap_q;
        acc_d     = acc_q;
        out_din_d = out_din_q;
        // reset gating keeps the pop strobe quiet while reset is held
        rd_en     = reset && (state_q == S_FILL) && !bus.in_empty;
        wr_en     = (state_q == S_OUT) && !bus.out_full;

        case (state_q)
            S_FILL: begin
                if (rd_en) begin
                    x_d[0] = bus.in_dout;
                    for (int k = 1; k < TAPS; k++) begin
                        x_d[k] = x_q[k-1];
                    end
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        acc_d   = '0;
                        tap_d   = '0;
                        state_d = S_MAC;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            S_MAC: begin
                acc_d = acc_q + deq;
                tap_d = tap_q + 1'b1;
                if (tap_q == TAP_LAST) begin
                    out_din_d = acc_q + deq;
                    tap_d     = '0;
                    state_d   = S_OUT;
                end
            end
            S_OUT: begin
                if (!bus.out_full) begin
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // State registers; reset discards any block in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FILL;
            phase_q   <= '0;
            tap_q     <= '0;
            acc_q     <= '0;
            out_din_q <= '0;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            tap_q     <= tap_d;
            acc_q     <= acc_d;
            out_din_q <= out_din_d;
            x_q       <= x_d;
        end
    end

    assign bus.in_rd_en  = rd_en;
    assign bus.out_wr_en = wr_en;
    assign bus.out_din   = out_din_q;

endmodule

// File: tb/tb_fir_decim.sv
// Bench for fir_decim: three filter instances (unit impulse, all-ones, mixed
// coefficients) driven from table rows and hand sequences; outputs are compared
// against fixed expectations or an arithmetic model of the filter equation.
module tb_fir_decim;
    localparam int TAPS = 32;
    localparam int DECIM = 8;
    localparam int DW = 32;
    localparam int BITS = 10;
    localparam int NDUT = 3;
    localparam int NVEC = 9;

    typedef logic signed [DW-1:0] word_t;

    localparam word_t COEF_B [TAPS] = '{default: 32'sh400};
    localparam word_t COEF_C [TAPS] = '{
        32'sh200, 32'sh0, 32'sh0, 32'sh0, 32'sh0, 32'sh0, 32'sh0, 32'sh0,
        32'sh1F3, -32'sh2A7, 32'sh7FFF, -32'sh1, 32'sh3C, 32'sh12345, -32'sh8001, 32'sh400,
        32'sh5, -32'sh5, 32'sh7FFFFFFF, 32'sh80000000, 32'sh333, -32'sh777, 32'sh10, 32'sh0,
        -32'sh3FF, 32'sh401, 32'sh1000, -32'sh1000, 32'sh9, -32'sh9, 32'sh2, -32'sh4};

    typedef struct {
        int          dut;
        int          kind;   // 0 ramp 1,2,3..; 1 constant val; 2 random
        logic [31:0] val;
        int          n;
        int          stall;  // percent of cycles with input FIFO empty
        bit          hold;   // hold output FIFO full for 50 cycles at first result
        int          nexp;   // -1: expectations from the model
        logic [31:0] exp [6];
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n [NDUT];
    logic [31:0] din   [NDUT];
    logic        empty [NDUT];
    logic        full  [NDUT];
    logic        rd    [NDUT];
    logic        wr    [NDUT];
    logic [31:0] dout  [NDUT];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [31:0] stim [$];
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];
    int          pop_cyc [$];
    int          wr_cyc [$];
    vec_t        tbl [NVEC];

    always #5 clk = ~clk;

    fir_decim_if #(.DATA_WIDTH(DW)) bus0 ();
    fir_decim_if #(.DATA_WIDTH(DW)) bus1 ();
    fir_decim_if #(.DATA_WIDTH(DW)) bus2 ();

    assign bus0.in_dout = din[0];
    assign bus0.in_empty = empty[0];
    assign bus0.out_full = full[0];
    assign rd[0] = bus0.in_rd_en;
    assign wr[0] = bus0.out_wr_en;
    assign dout[0] = bus0.out_din;

    assign bus1.in_dout = din[1];
    assign bus1.in_empty = empty[1];
    assign bus1.out_full = full[1];
    assign rd[1] = bus1.in_rd_en;
    assign wr[1] = bus1.out_wr_en;
    assign dout[1] = bus1.out_din;

    assign bus2.in_dout = din[2];
    assign bus2.in_empty = empty[2];
    assign bus2.out_full = full[2];
    assign rd[2] = bus2.in_rd_en;
    assign wr[2] = bus2.out_wr_en;
    assign dout[2] = bus2.out_din;

    fir_decim #(.TAPS(TAPS), .DECIM(DECIM), .DATA_WIDTH(DW), .BITS(BITS)) dut_a (
        .clk(clk), .reset(rst_n[0]), .bus(bus0));
    fir_decim #(.TAPS(TAPS), .DECIM(DECIM), .DATA_WIDTH(DW), .BITS(BITS), .COEFFS(COEF_B)) dut_b (
        .clk(clk), .reset(rst_n[1]), .bus(bus1));
    fir_decim #(.TAPS(TAPS), .DECIM(DECIM), .DATA_WIDTH(DW), .BITS(BITS), .COEFFS(COEF_C)) dut_c (
        .clk(clk), .reset(rst_n[2]), .bus(bus2));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    function automatic word_t coef_of(input int d, input int k);
        if (d == 0) return (k == 0) ? 32'sh400 : 32'sh0;
        if (d == 1) return COEF_B[k];
        return COEF_C[k];
    endfunction

    // y[j] = sum_k trunc0(c[k] * x[j*DECIM-1-k] / 2^BITS), 32-bit wrap, x before start = 0
    function automatic void build_model(input int d);
        int     acc;
        int     idx;
        longint xv;
        longint p;
        exp_q.delete();
        for (int j = 1; j <= stim.size() / DECIM; j++) begin
            acc = 0;
            for (int k = 0; k < TAPS; k++) begin
                idx = j * DECIM - 1 - k;
                xv = (idx >= 0) ? longint'($signed(stim[idx])) : 64'sd0;
                p = longint'(coef_of(d, k)) * xv;
                acc += int'(p / (64'sd1 << BITS));
            end
            exp_q.push_back(acc);
        end
    endfunction

    function automatic vec_t mk(input int dut, input int kind, input logic [31:0] val,
                                input int n, input int stall, input bit hold, input int nexp,
                                input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                                input logic [31:0] e3, input logic [31:0] e4, input logic [31:0] e5);
        vec_t v;
        v.dut = dut; v.kind = kind; v.val = val; v.n = n;
        v.stall = stall; v.hold = hold; v.nexp = nexp;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
        v.exp[3] = e3; v.exp[4] = e4; v.exp[5] = e5;
        return v;
    endfunction

    task automatic reset_dut(input int d);
        rst_n[d] = 1'b0;
        empty[d] = 1'b0;
        full[d] = 1'b0;
        din[d] = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_rd_en", 64'(rd[d]), 64'd0);
        check("reset_wr_en", 64'(wr[d]), 64'd0);
        check("reset_out_din", 64'(dout[d]), 64'd0);
        empty[d] = 1'b1;
        rst_n[d] = 1'b1;
    endtask

    // Feeds stim[] as a FIFO and collects writes; stops once all pops and
    // expected writes are seen plus a margin that would expose stray writes.
    task automatic run_stream(input int d, input int stall_pct, input bit full_hold, input int budget);
        int pos = 0;
        int nexp;
        int hold_start = -1;
        int release_cyc = -1;
        int hold_seen = 0;
        int bad_rd = 0;
        int bad_hold = 0;
        int idle = 0;
        logic [31:0] held = '0;
        nexp = stim.size() / DECIM;
        got_q.delete();
        pop_cyc.delete();
        wr_cyc.delete();
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            cyc++;
            empty[d] = (pos >= stim.size()) || (int'($urandom_range(99)) < stall_pct);
            din[d] = empty[d] ? $urandom : stim[pos];
            full[d] = full_hold && (release_cyc < 0 || cyc < release_cyc);
            #1;
            if (rd[d] && empty[d]) bad_rd++;
            if (hold_start >= 0 && cyc >= hold_start && cyc < release_cyc) begin
                if (cyc == hold_start) held = dout[d];
                hold_seen++;
                if (rd[d] || wr[d] || dout[d] !== held) bad_hold++;
            end
            if (rd[d]) begin
                pop_cyc.push_back(cyc);
                pos++;
                if (full_hold && pos == DECIM) begin
                    hold_start = cyc + TAPS + 1;
                    release_cyc = hold_start + 50;
                end
            end
            if (wr[d]) begin
                got_q.push_back(dout[d]);
                wr_cyc.push_back(cyc);
            end
            if (pos == stim.size() && got_q.size() >= nexp) idle++;
            if (idle > TAPS + DECIM + 4) break;
        end
        check("all_inputs_popped", 64'(pos), 64'(stim.size()));
        check("rd_en_while_empty", 64'(bad_rd), 64'd0);
        if (full_hold) begin
            check("hold_window_cycles", 64'(hold_seen), 64'd50);
            check("hold_window_quiet", 64'(bad_hold), 64'd0);
        end
        for (int j = 0; j < got_q.size(); j++) begin
            if ((j + 1) * DECIM - 1 < pop_cyc.size()) begin
                check("latency", 64'(wr_cyc[j] - pop_cyc[(j + 1) * DECIM - 1]),
                      64'(TAPS + 1 + ((full_hold && j == 0) ? 50 : 0)));
            end
            if (j > 0 && stall_pct == 0 && !full_hold) begin
                check("period", 64'(wr_cyc[j] - wr_cyc[j-1]), 64'(DECIM + TAPS + 1));
            end
        end
    endtask

    initial begin
        int d;
        int nexp;
        int bad;
        logic [31:0] e;
        logic [31:0] g;

        for (int i = 0; i < NDUT; i++) begin
            rst_n[i] = 1'b0;
            din[i] = '0;
            empty[i] = 1'b1;
            full[i] = 1'b0;
        end

        tbl[0] = mk(0, 0, 0, 16, 0, 0, 2, 8, 16, 0, 0, 0, 0);
        tbl[1] = mk(2, 1, 32'hFFFFFFFD, 8, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        tbl[2] = mk(1, 1, 5, 48, 0, 0, 6, 40, 80, 120, 160, 160, 160);
        tbl[3] = mk(0, 0, 0, 16, 50, 0, 2, 8, 16, 0, 0, 0, 0);
        tbl[4] = mk(0, 0, 0, 8, 0, 1, 1, 8, 0, 0, 0, 0, 0);
        tbl[5] = mk(2, 2, 0, 100, 0, 0, -1, 0, 0, 0, 0, 0, 0);
        tbl[6] = mk(2, 2, 0, 100, 40, 0, -1, 0, 0, 0, 0, 0, 0);
        tbl[7] = mk(1, 2, 0, 37, 30, 0, -1, 0, 0, 0, 0, 0, 0);
        tbl[8] = mk(0, 2, 0, 24, 0, 0, -1, 0, 0, 0, 0, 0, 0);

        for (int v = 0; v < NVEC; v++) begin
            d = tbl[v].dut;
            reset_dut(d);
            stim.delete();
            for (int i = 0; i < tbl[v].n; i++) begin
                case (tbl[v].kind)
                    0: stim.push_back(32'(i + 1));
                    1: stim.push_back(tbl[v].val);
                    default: stim.push_back($urandom);
                endcase
            end
            build_model(d);
            run_stream(d, tbl[v].stall, tbl[v].hold, 5000);
            nexp = (tbl[v].nexp < 0) ? exp_q.size() : tbl[v].nexp;
            check("output_count", 64'(got_q.size()), 64'(nexp));
            for (int j = 0; j < nexp; j++) begin
                e = (tbl[v].nexp < 0) ? exp_q[j] : tbl[v].exp[j];
                g = (j < got_q.size()) ? got_q[j] : 32'hxxxxxxxx;
                $display("vec %0d dut %0d out[%0d] = %h expected %h", v, d, j, g, e);
                check("output_value", 64'(g), 64'(e));
            end
        end

        // Reset during the MAC of a second block, with a stale result in out_din
        d = 2;
        reset_dut(d);
        stim.delete();
        for (int i = 0; i < DECIM; i++) stim.push_back($urandom);
        run_stream(d, 0, 1'b0, 500);
        check("pre_reset_output_count", 64'(got_q.size()), 64'd1);
        bad = 0;
        for (int i = 0; i < DECIM; i++) begin
            @(negedge clk);
            cyc++;
            empty[d] = 1'b0;
            din[d] = $urandom;
            #1;
            if (!rd[d]) bad++;
        end
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            cyc++;
            din[d] = $urandom;
            #1;
            if (rd[d] || wr[d]) bad++;
        end
        check("second_block_fill_and_mac", 64'(bad), 64'd0);
        @(negedge clk);
        cyc++;
        rst_n[d] = 1'b0;
        #1;
        check("midmac_reset_rd_en", 64'(rd[d]), 64'd0);
        check("midmac_reset_wr_en", 64'(wr[d]), 64'd0);
        check("midmac_reset_out_din", 64'(dout[d]), 64'd0);
        @(negedge clk);
        cyc++;
        rst_n[d] = 1'b1;
        empty[d] = 1'b1;
        stim.delete();
        for (int i = 0; i < DECIM; i++) stim.push_back($urandom);
        build_model(d);
        run_stream(d, 0, 1'b0, 500);
        check("post_reset_output_count", 64'(got_q.size()), 64'd1);
        g = (got_q.size() > 0) ? got_q[0] : 32'hxxxxxxxx;
        $display("post-reset dut %0d out[0] = %h expected %h", d, g, exp_q[0]);
        check("post_reset_output_value", 64'(g), 64'(exp_q[0]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
